// File: rtl/bulk_endp_mc_pkg.sv
// -----------------------------------------------------------------------------
// bulk_endp_mc_pkg
// Shared definitions for the multi-channel bulk endpoint buffer:
//   - USB endpoint transfer-type codes (control / bulk / interrupt)
//   - IN-path packet state encoding
//   - clog2 helper for sizing pointers from FIFO depths
// No ports (package).
// -----------------------------------------------------------------------------
package bulk_endp_mc_pkg;

  localparam logic [1:0] ENDP_CTRL = 2'd0;
  localparam logic [1:0] ENDP_BULK = 2'd2;
  localparam logic [1:0] ENDP_INT  = 2'd3;

  typedef enum logic [1:0] {
    IN_IDLE     = 2'd0,
    IN_SEND     = 2'd1,
    IN_WAIT_ACK = 2'd2
  } in_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bulk_endp_mc_fifo_rb.sv
// -----------------------------------------------------------------------------
// bulk_endp_mc_fifo_rb
// Byte FIFO with one speculative pointer plus its committed shadow.
// SPEC_WR=1: the write side is speculative (OUT packets, discarded on error).
// SPEC_WR=0: the read side is speculative (IN packets, replayed on retry).
// Pointers are AW+1 bits and wrap naturally; occupancy is a plain difference.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en, wr_data        push one byte at wr_ptr
//   rd_en                 advance rd_ptr
//   commit                committed shadow takes the speculative pointer
//   rollback              speculative pointer returns to the committed shadow
//   wr_ptr, rd_ptr        current write / read pointers
//   com_ptr               committed copy of the speculative side
//   rd_data               byte at rd_ptr
// -----------------------------------------------------------------------------
module bulk_endp_mc_fifo_rb
  import bulk_endp_mc_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter bit SPEC_WR = 1'b1,
  localparam int AW     = clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
  input  logic        commit,
  input  logic        rollback,
  output logic [AW:0] wr_ptr,
  output logic [AW:0] rd_ptr,
  output logic [AW:0] com_ptr,
  output logic [7:0]  rd_data
);

  logic [7:0] mem [DEPTH];

  // Storage carries no reset; only pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      com_ptr <= '0;
    end else if (SPEC_WR) begin
      if (rollback)   wr_ptr <= com_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (commit)     com_ptr <= wr_ptr;
      if (rd_en)      rd_ptr <= rd_ptr + (AW+1)'(1);
    end else begin
      if (wr_en)      wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rollback)   rd_ptr <= com_ptr;
      else if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (commit)     com_ptr <= rd_ptr;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bulk_endp_mc.sv
// -----------------------------------------------------------------------------
// bulk_endp_mc
// N_CHANNELS bulk IN/OUT pipes sharing one SIE endpoint interface. Channel c
// answers on endpoint FIRST_ENDP+c. OUT packets are written speculatively and
// committed on ACK or dropped on error/overflow; IN packets are read
// speculatively and replayed until the host ACKs. A max-size IN packet is
// followed by a zero-length packet on the next IN token with an empty FIFO.
// Ports:
//   clk_i, rstn_i                        clock, asynchronous active-low reset
//   endp_i                               endpoint of current SIE transaction
//   out_data_i/out_valid_i               OUT payload byte strobe
//   out_err_i/out_ready_i                OUT packet discard / commit
//   out_nak_o                            selected channel lacks a max packet
//   in_req_i/in_ready_i/in_ack_i         IN token / byte consumed / host ACK
//   in_data_o/in_valid_o/in_zlp_o        IN byte, byte valid, send ZLP
//   app_out_data_o/valid_o/ready_i       per-channel OUT byte stream
//   app_in_data_i/valid_i/ready_o        per-channel IN byte stream
// -----------------------------------------------------------------------------
module bulk_endp_mc
  import bulk_endp_mc_pkg::*;
#(
  parameter int N_CHANNELS             = 2,
  parameter int FIRST_ENDP             = 1,
  parameter int IN_BULK_MAXPACKETSIZE  = 8,
  parameter int OUT_BULK_MAXPACKETSIZE = 8,
  parameter int IN_FIFO_DEPTH          = 16,
  parameter int OUT_FIFO_DEPTH         = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [3:0]              endp_i,
  input  logic [7:0]              out_data_i,
  input  logic                    out_valid_i,
  input  logic                    out_err_i,
  input  logic                    out_ready_i,
  output logic                    out_nak_o,
  input  logic                    in_req_i,
  input  logic                    in_ready_i,
  input  logic                    in_ack_i,
  output logic [7:0]              in_data_o,
  output logic                    in_valid_o,
  output logic                    in_zlp_o,
  output logic [8*N_CHANNELS-1:0] app_out_data_o,
  output logic [N_CHANNELS-1:0]   app_out_valid_o,
  input  logic [N_CHANNELS-1:0]   app_out_ready_i,
  input  logic [8*N_CHANNELS-1:0] app_in_data_i,
  input  logic [N_CHANNELS-1:0]   app_in_valid_i,
  output logic [N_CHANNELS-1:0]   app_in_ready_o
);

  localparam int OAW = clog2(OUT_FIFO_DEPTH);
  localparam int IAW = clog2(IN_FIFO_DEPTH);
  localparam int LW  = clog2(IN_BULK_MAXPACKETSIZE) + 1;

  localparam logic [OAW:0]  O_DEPTH   = (OAW+1)'(OUT_FIFO_DEPTH);
  // NAK when free < MPS, i.e. when committed occupancy exceeds DEPTH-MPS.
  localparam logic [OAW:0]  O_NAK_LIM = (OAW+1)'(OUT_FIFO_DEPTH - OUT_BULK_MAXPACKETSIZE);
  localparam logic [IAW:0]  I_DEPTH   = (IAW+1)'(IN_FIFO_DEPTH);
  localparam logic [IAW:0]  I_MPS     = (IAW+1)'(IN_BULK_MAXPACKETSIZE);
  localparam logic [LW-1:0] L_MPS     = LW'(IN_BULK_MAXPACKETSIZE);

  logic [N_CHANNELS-1:0] hit, ch_valid, ch_zlp, ch_nak;
  logic [7:0]            ch_data [N_CHANNELS];

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    assign hit[c] = (endp_i == 4'(FIRST_ENDP + c));

    // ---------------- OUT path ----------------
    logic [OAW:0] o_wr, o_rd, o_com;
    logic [7:0]   o_q;
    logic         o_ovf, o_full, o_wr_en, o_rd_en, o_commit, o_rollback;

    assign o_full     = (o_wr - o_rd) == O_DEPTH;
    assign o_wr_en    = hit[c] & out_valid_i & ~o_full;
    assign o_commit   = hit[c] & out_ready_i & ~o_ovf;
    // An overflowed packet is incomplete, so an ACK for it still discards it.
    assign o_rollback = hit[c] & (out_err_i | (out_ready_i & o_ovf));
    assign o_rd_en    = app_out_valid_o[c] & app_out_ready_i[c];

    assign app_out_valid_o[c]     = (o_com != o_rd);
    assign app_out_data_o[8*c +: 8] = app_out_valid_o[c] ? o_q : 8'h00;
    assign ch_nak[c]              = (o_com - o_rd) > O_NAK_LIM;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)                                 o_ovf <= 1'b0;
      else if (hit[c] & (out_ready_i | out_err_i)) o_ovf <= 1'b0;
      else if (hit[c] & out_valid_i & o_full)      o_ovf <= 1'b1;
    end

    bulk_endp_mc_fifo_rb #(.DEPTH(OUT_FIFO_DEPTH), .SPEC_WR(1'b1)) u_out (
      .clk(clk_i), .rst_n(rstn_i),
      .wr_en(o_wr_en), .wr_data(out_data_i), .rd_en(o_rd_en),
      .commit(o_commit), .rollback(o_rollback),
      .wr_ptr(o_wr), .rd_ptr(o_rd), .com_ptr(o_com), .rd_data(o_q)
    );

    // ---------------- IN path ----------------
    in_state_e     state, n_state;
    logic [LW-1:0] len, n_len, left, n_left, snap;
    logic          zlp_mode, n_zlp, zlp_pend, n_pend;
    logic [IAW:0]  i_wr, i_rd, i_com, i_used;
    logic [7:0]    i_q;
    logic          i_wr_en, i_rd_en, i_commit, do_snap, req, ack, rdy;

    assign req  = hit[c] & in_req_i;
    assign ack  = hit[c] & in_ack_i;
    assign rdy  = hit[c] & in_ready_i;

    // Occupancy counts from the committed read pointer, so bytes of an
    // unacknowledged packet keep their space until the host ACKs.
    assign i_used            = i_wr - i_com;
    assign app_in_ready_o[c] = i_used < I_DEPTH;
    assign i_wr_en           = app_in_valid_i[c] & app_in_ready_o[c];
    assign snap              = (i_used >= I_MPS) ? L_MPS : LW'(i_used);

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        state    <= IN_IDLE;
        len      <= '0;
        left     <= '0;
        zlp_mode <= 1'b0;
        zlp_pend <= 1'b0;
      end else begin
        state    <= n_state;
        len      <= n_len;
        left     <= n_left;
        zlp_mode <= n_zlp;
        zlp_pend <= n_pend;
      end
    end

    always_comb begin
      n_state  = state;
      n_len    = len;
      n_left   = left;
      n_zlp    = zlp_mode;
      n_pend   = zlp_pend;
      do_snap  = 1'b0;
      i_commit = 1'b0;
      i_rd_en  = 1'b0;
      case (state)
        IN_IDLE: do_snap = req;
        IN_SEND: begin
          if (zlp_mode) begin
            n_state = IN_WAIT_ACK;
          end else if (rdy && left != '0) begin
            i_rd_en = 1'b1;
            n_left  = left - LW'(1);
            if (left == LW'(1)) n_state = IN_WAIT_ACK;
          end
        end
        IN_WAIT_ACK: begin
          if (ack) begin
            i_commit = 1'b1;
            n_pend   = (len == L_MPS);
            n_state  = IN_IDLE;
          end else begin
            do_snap = req;
          end
        end
        default: n_state = IN_IDLE;
      endcase
      // A fresh token and a retry both restart from the committed pointer,
      // so a replayed packet carries exactly the same bytes.
      if (do_snap) begin
        n_len  = snap;
        n_left = snap;
        n_zlp  = 1'b0;
        if (snap != '0) begin
          n_state = IN_SEND;
        end else if (zlp_pend) begin
          n_state = IN_SEND;
          n_zlp   = 1'b1;
        end else begin
          n_state = IN_IDLE;
        end
      end
    end

    assign ch_valid[c] = (state == IN_SEND) & ~zlp_mode & (left != '0);
    assign ch_zlp[c]   = (state == IN_SEND) & zlp_mode;
    assign ch_data[c]  = i_q;

    bulk_endp_mc_fifo_rb #(.DEPTH(IN_FIFO_DEPTH), .SPEC_WR(1'b0)) u_in (
      .clk(clk_i), .rst_n(rstn_i),
      .wr_en(i_wr_en), .wr_data(app_in_data_i[8*c +: 8]), .rd_en(i_rd_en),
      .commit(i_commit), .rollback(do_snap),
      .wr_ptr(i_wr), .rd_ptr(i_rd), .com_ptr(i_com), .rd_data(i_q)
    );
  end

  // SIE-facing mux: an endpoint outside the channel range drives all zeros.
  always_comb begin
    in_valid_o = 1'b0;
    in_zlp_o   = 1'b0;
    out_nak_o  = 1'b0;
    in_data_o  = 8'h00;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (hit[c]) begin
        in_valid_o = ch_valid[c];
        in_zlp_o   = ch_zlp[c];
        out_nak_o  = ch_nak[c];
        in_data_o  = ch_valid[c] ? ch_data[c] : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_bulk_endp_mc.sv
// -----------------------------------------------------------------------------
// tb_bulk_endp_mc
// Self-checking bench for bulk_endp_mc (2 channels on endpoints 1 and 2).
// Reference model: per-channel byte queues. OUT keeps a committed queue plus
// the packet in progress; IN keeps every byte not yet acknowledged by the host.
// -----------------------------------------------------------------------------
module tb_bulk_endp_mc;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  endp = 4'd0;
  logic [7:0]  out_data = 8'h00;
  logic        out_valid = 1'b0, out_err = 1'b0, out_ready = 1'b0;
  logic        out_nak;
  logic        in_req = 1'b0, in_ready = 1'b0, in_ack = 1'b0;
  logic [7:0]  in_data;
  logic        in_valid, in_zlp;
  logic [15:0] app_out_data;
  logic [1:0]  app_out_valid;
  logic [1:0]  app_out_ready = 2'b00;
  logic [15:0] app_in_data = 16'h0000;
  logic [1:0]  app_in_valid = 2'b00;
  logic [1:0]  app_in_ready;

  always #5 clk = ~clk;

  bulk_endp_mc #(
    .N_CHANNELS(2), .FIRST_ENDP(1),
    .IN_BULK_MAXPACKETSIZE(8), .OUT_BULK_MAXPACKETSIZE(8),
    .IN_FIFO_DEPTH(16), .OUT_FIFO_DEPTH(16)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .endp_i(endp),
    .out_data_i(out_data), .out_valid_i(out_valid), .out_err_i(out_err),
    .out_ready_i(out_ready), .out_nak_o(out_nak),
    .in_req_i(in_req), .in_ready_i(in_ready), .in_ack_i(in_ack),
    .in_data_o(in_data), .in_valid_o(in_valid), .in_zlp_o(in_zlp),
    .app_out_data_o(app_out_data), .app_out_valid_o(app_out_valid),
    .app_out_ready_i(app_out_ready),
    .app_in_data_i(app_in_data), .app_in_valid_i(app_in_valid),
    .app_in_ready_o(app_in_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] ocom [2][$];
  logic [7:0] opkt [2][$];
  bit         oovf [2];
  logic [7:0] iq   [2][$];
  bit         zpend [2];

  typedef struct {
    logic [3:0] endp;
    int         len;
    logic [7:0] base;
    bit         err;
    logic [1:0] exp_valid;
    logic [7:0] exp_d0;
    logic [7:0] exp_d1;
    bit         exp_nak;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ch_of(input logic [3:0] e);
    if (e == 4'd1) return 0;
    if (e == 4'd2) return 1;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      ocom[c].delete();
      opkt[c].delete();
      iq[c].delete();
      oovf[c]  = 1'b0;
      zpend[c] = 1'b0;
    end
  endtask

  task automatic out_pkt(input logic [3:0] e, input int len, input logic [7:0] base, input bit err);
    int c;
    c = ch_of(e);
    endp = e;
    for (int i = 0; i < len; i++) begin
      out_data  = base + 8'(i);
      out_valid = 1'b1;
      tick();
      out_valid = 1'b0;
      if (c >= 0) begin
        if (ocom[c].size() + opkt[c].size() < 16) opkt[c].push_back(base + 8'(i));
        else oovf[c] = 1'b1;
      end
    end
    if (err) out_err = 1'b1;
    else     out_ready = 1'b1;
    tick();
    out_err   = 1'b0;
    out_ready = 1'b0;
    if (c >= 0) begin
      if (!err && !oovf[c]) begin
        while (opkt[c].size() > 0) ocom[c].push_back(opkt[c].pop_front());
      end
      opkt[c].delete();
      oovf[c] = 1'b0;
    end
  endtask

  task automatic app_read(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("app_out_valid[%0d]", c), 32'(app_out_valid[c]), 32'(ocom[c].size() != 0));
      if (ocom[c].size() == 0) break;
      chk($sformatf("app_out_data[%0d]", c), 32'(app_out_data[8*c +: 8]), 32'(ocom[c][0]));
      app_out_ready[c] = 1'b1;
      tick();
      app_out_ready[c] = 1'b0;
      void'(ocom[c].pop_front());
    end
  endtask

  task automatic app_push(input int c, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("app_in_ready[%0d]", c), 32'(app_in_ready[c]), 32'(iq[c].size() < 16));
      app_in_data[8*c +: 8] = base + 8'(i);
      app_in_valid[c] = 1'b1;
      tick();
      app_in_valid[c] = 1'b0;
      if (iq[c].size() < 16) iq[c].push_back(base + 8'(i));
    end
  endtask

  task automatic in_txn(input logic [3:0] e, input bit do_ack);
    int c, len;
    c = ch_of(e);
    endp = e;
    in_req = 1'b1;
    tick();
    in_req = 1'b0;
    if (c < 0) begin
      chk("unsel_in_valid", 32'(in_valid), 32'd0);
      chk("unsel_in_zlp", 32'(in_zlp), 32'd0);
      chk("unsel_in_data", 32'(in_data), 32'd0);
      return;
    end
    len = (iq[c].size() < 8) ? iq[c].size() : 8;
    if (len == 0) begin
      chk("in_zlp", 32'(in_zlp), 32'(zpend[c]));
      chk("in_valid_nodata", 32'(in_valid), 32'd0);
      if (!zpend[c]) return;
      tick();
      chk("in_zlp_after", 32'(in_zlp), 32'd0);
    end else begin
      for (int i = 0; i < len; i++) begin
        chk("in_valid", 32'(in_valid), 32'd1);
        chk("in_data", 32'(in_data), 32'(iq[c][i]));
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
      end
      chk("in_valid_end", 32'(in_valid), 32'd0);
    end
    if (do_ack) begin
      in_ack = 1'b1;
      tick();
      in_ack = 1'b0;
      repeat (len) void'(iq[c].pop_front());
      zpend[c] = (len == 8);
    end
  endtask

  task automatic chk_nak(input logic [3:0] e);
    int c;
    c = ch_of(e);
    endp = e;
    #1;
    chk($sformatf("out_nak endp%0d", e), 32'(out_nak),
        32'(c >= 0 && (16 - ocom[c].size() < 8)));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'd2, 8, 8'h01, 1'b0, 2'b10, 8'h00, 8'h01, 1'b0};
    tbl[1] = '{4'd1, 5, 8'h30, 1'b1, 2'b10, 8'h00, 8'h01, 1'b0};
    tbl[2] = '{4'd1, 3, 8'hA0, 1'b0, 2'b11, 8'hA0, 8'h01, 1'b0};
    tbl[3] = '{4'd3, 4, 8'h55, 1'b0, 2'b11, 8'hA0, 8'h01, 1'b0};
    tbl[4] = '{4'd0, 2, 8'h66, 1'b0, 2'b11, 8'hA0, 8'h01, 1'b0};
    tbl[5] = '{4'd2, 1, 8'h09, 1'b0, 2'b11, 8'hA0, 8'h01, 1'b1};
    model_clear();

    // Reset state
    #1 rstn = 1'b0;
    endp = 4'd1;
    repeat (3) tick();
    chk("rst app_in_ready", 32'(app_in_ready), 32'h3);
    chk("rst app_out_valid", 32'(app_out_valid), 32'h0);
    chk("rst app_out_data", 32'(app_out_data), 32'h0);
    chk("rst in_valid", 32'(in_valid), 32'h0);
    chk("rst in_zlp", 32'(in_zlp), 32'h0);
    chk("rst out_nak", 32'(out_nak), 32'h0);
    chk("rst in_data", 32'(in_data), 32'h0);
    rstn = 1'b1;
    tick();

    // Table-driven OUT packets
    for (int r = 0; r < 6; r++) begin
      out_pkt(tbl[r].endp, tbl[r].len, tbl[r].base, tbl[r].err);
      chk($sformatf("tbl%0d app_out_valid", r), 32'(app_out_valid), 32'(tbl[r].exp_valid));
      chk($sformatf("tbl%0d app_out_data0", r), 32'(app_out_data[7:0]), 32'(tbl[r].exp_d0));
      chk($sformatf("tbl%0d app_out_data1", r), 32'(app_out_data[15:8]), 32'(tbl[r].exp_d1));
      chk($sformatf("tbl%0d out_nak", r), 32'(out_nak), 32'(tbl[r].exp_nak));
    end
    app_read(0, 3);
    app_read(1, 9);
    chk("drained app_out_valid", 32'(app_out_valid), 32'h0);

    // NAK threshold and overflow rollback on channel 0
    out_pkt(4'd1, 9, 8'h20, 1'b0);
    endp = 4'd1; #1;
    chk("nak 9 committed", 32'(out_nak), 32'd1);
    endp = 4'd2; #1;
    chk("nak other channel", 32'(out_nak), 32'd0);
    endp = 4'd1;
    app_read(0, 1);
    chk("nak 8 committed", 32'(out_nak), 32'd0);
    app_read(0, 1);
    chk_nak(4'd1);
    out_pkt(4'd1, 10, 8'hC0, 1'b0);
    chk_nak(4'd1);
    out_pkt(4'd1, 9, 8'hD0, 1'b0);
    endp = 4'd1; #1;
    chk("nak full", 32'(out_nak), 32'd1);
    app_read(0, 17);

    // IN: retry resends identical bytes, then ZLP termination
    app_push(0, 8, 8'h10);
    in_txn(4'd1, 1'b0);
    in_txn(4'd1, 1'b1);
    chk("zlp pending model", 32'(zpend[0]), 32'd1);
    in_txn(4'd1, 1'b1);
    in_txn(4'd1, 1'b0);

    // IN: bytes written during SEND stay out of the in-flight packet
    app_push(1, 3, 8'h40);
    endp = 4'd2;
    in_req = 1'b1; tick(); in_req = 1'b0;
    app_push(1, 2, 8'h50);
    for (int i = 0; i < 3; i++) begin
      chk("excl in_valid", 32'(in_valid), 32'd1);
      chk("excl in_data", 32'(in_data), 32'(8'h40 + 8'(i)));
      in_ready = 1'b1; tick(); in_ready = 1'b0;
    end
    chk("excl end", 32'(in_valid), 32'd0);
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    repeat (3) void'(iq[1].pop_front());
    zpend[1] = 1'b0;
    in_txn(4'd2, 1'b1);

    // Asynchronous reset in the middle of an IN packet
    app_push(0, 16, 8'h80);
    chk("in fifo full", 32'(app_in_ready[0]), 32'd0);
    out_pkt(4'd2, 3, 8'h70, 1'b0);
    endp = 4'd1;
    in_req = 1'b1; tick(); in_req = 1'b0;
    in_ready = 1'b1; tick(); in_ready = 1'b0;
    chk("pre-reset in_valid", 32'(in_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async rst in_valid", 32'(in_valid), 32'd0);
    chk("async rst app_out_valid", 32'(app_out_valid), 32'h0);
    chk("async rst app_in_ready", 32'(app_in_ready), 32'h3);
    chk("async rst in_data", 32'(in_data), 32'h0);
    tick(); tick();
    rstn = 1'b1;
    model_clear();
    tick();

    // Randomized traffic against the queue model
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 4))
        0: out_pkt(4'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 8'($urandom),
                   $urandom_range(0, 3) == 0);
        1: app_read(int'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
        2: app_push(int'($urandom_range(0, 1)), int'($urandom_range(1, 10)), 8'($urandom));
        3: in_txn(4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        default: chk_nak(4'($urandom_range(0, 3)));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
